// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset/lock sequencer: state encoding and
// counter sizing helper.
package pll_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } seq_state_e;

    // Width needed to count up to the largest terminal value (max - 1), never below 1.
    function automatic int calc_cnt_w(input int rst_cycles, input int timeout_cycles,
                                      input int stable_cycles);
        int max_v;
        max_v = rst_cycles;
        if (timeout_cycles > max_v) begin
            max_v = timeout_cycles;
        end else begin
            max_v = max_v;
        end
        if (stable_cycles > max_v) begin
            max_v = stable_cycles;
        end else begin
            max_v = max_v;
        end
        if (max_v < 2) begin
            return 1;
        end else begin
            return $clog2(max_v);
        end
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; both stages reset to 0.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Synchroniser chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset pulse generator and lock supervisor: releases sys_reset_n only after
// a stable lock, re-sequences on lock loss, and faults after a bounded retry count.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 10,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 7,
    localparam int RW = ($clog2(MAX_RETRIES + 1) < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pll_locked,
    input  logic               force_relock,
    output logic               pll_rst,
    output logic               sys_reset_n,
    output logic               fault,
    output logic [STATE_W-1:0] state,
    output logic [RW-1:0]      retry_count
);

    localparam int CW = calc_cnt_w(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

    seq_state_e    state_r;
    seq_state_e    nxt_state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] nxt_cnt_s;
    logic [RW-1:0] retry_r;
    logic [RW-1:0] nxt_retry_s;
    logic          pll_rst_r;
    logic          sys_reset_n_r;
    logic          fault_r;
    logic          locked_s;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (locked_s)
    );

    // State, counter and registered outputs; outputs are decoded from the next state
    // so they change in the same cycle the state does.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_PLL_RST;
            cnt_r         <= '0;
            retry_r       <= '0;
            pll_rst_r     <= 1'b1;
            sys_reset_n_r <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            state_r       <= nxt_state_s;
            cnt_r         <= nxt_cnt_s;
            retry_r       <= nxt_retry_s;
            pll_rst_r     <= (nxt_state_s == ST_PLL_RST);
            sys_reset_n_r <= (nxt_state_s == ST_RUN);
            fault_r       <= (nxt_state_s == ST_FAULT);
        end
    end

    // Next-state logic. force_relock outranks lock and timeout events; lock loss
    // outranks settle completion so RUN is never entered on a dropped lock.
    always_comb begin
        nxt_state_s = state_r;
        nxt_cnt_s   = cnt_r;
        nxt_retry_s = retry_r;
        case (state_r)
            ST_PLL_RST: begin
                if (cnt_r == RST_LAST) begin
                    nxt_state_s = ST_WAIT_LOCK;
                    nxt_cnt_s   = '0;
                end else begin
                    nxt_cnt_s = cnt_r + CW'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (force_relock) begin
                    nxt_state_s = ST_PLL_RST;
                    nxt_cnt_s   = '0;
                end else if (locked_s) begin
                    nxt_state_s = ST_SETTLE;
                    nxt_cnt_s   = '0;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    nxt_cnt_s = '0;
                    if (retry_r == RETRY_MAX) begin
                        nxt_state_s = ST_FAULT;
                    end else begin
                        nxt_state_s = ST_PLL_RST;
                        nxt_retry_s = retry_r + RW'(1);
                    end
                end else begin
                    nxt_cnt_s = cnt_r + CW'(1);
                end
            end
            ST_SETTLE: begin
                if (force_relock) begin
                    nxt_state_s = ST_PLL_RST;
                    nxt_cnt_s   = '0;
                end else if (!locked_s) begin
                    nxt_state_s = ST_WAIT_LOCK;
                    nxt_cnt_s   = '0;
                end else if (cnt_r == STABLE_LAST) begin
                    nxt_state_s = ST_RUN;
                    nxt_cnt_s   = '0;
                    nxt_retry_s = '0;
                end else begin
                    nxt_cnt_s = cnt_r + CW'(1);
                end
            end
            ST_RUN: begin
                if (force_relock || !locked_s) begin
                    nxt_state_s = ST_PLL_RST;
                    nxt_cnt_s   = '0;
                end else begin
                    nxt_cnt_s = '0;
                end
            end
            ST_FAULT: begin
                if (force_relock) begin
                    nxt_state_s = ST_PLL_RST;
                    nxt_cnt_s   = '0;
                    nxt_retry_s = '0;
                end else begin
                    nxt_cnt_s = '0;
                end
            end
            default: begin
                nxt_state_s = ST_PLL_RST;
                nxt_cnt_s   = '0;
            end
        endcase
    end

    assign pll_rst     = pll_rst_r;
    assign sys_reset_n = sys_reset_n_r;
    assign fault       = fault_r;
    assign state       = state_r;
    assign retry_count = retry_r;

endmodule
